// File: rtl/rle_vli_coder_if.sv
// Stream bundle for rle_vli_coder: coefficient input handshake and symbol output handshake.
interface rle_vli_coder_if #(
  parameter int DATA_WIDTH = 11,
  parameter int NUM_CH     = 3
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SIZE_W = $clog2(DATA_WIDTH + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [CH_W-1:0]       in_ch;
  logic                  in_restart;

  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            out_run;
  logic [SIZE_W-1:0]     out_size;
  logic [DATA_WIDTH-1:0] out_vli;
  logic                  out_isdc;
  logic                  out_eob;
  logic                  out_last;
  logic [CH_W-1:0]       out_ch;

  modport master (
    output in_valid, in_data, in_ch, in_restart, out_ready,
    input  in_ready, out_valid, out_run, out_size, out_vli,
           out_isdc, out_eob, out_last, out_ch
  );

  modport slave (
    input  in_valid, in_data, in_ch, in_restart, out_ready,
    output in_ready, out_valid, out_run, out_size, out_vli,
           out_isdc, out_eob, out_last, out_ch
  );
endinterface

// File: rtl/rle_vli_coder.sv
// Run-length / VLI symbol generator between the zig-zag stream and the Huffman coder.
// Optional macro RLE_VLI_STATS_EN adds the stat_zrl_drop counter port.
module rle_vli_coder #(
  parameter int DATA_WIDTH = 11,
  parameter int NUM_CH     = 3,
  parameter int BLOCK_LEN  = 64,
  parameter int RUN_MAX    = 15
) (
  input  logic           clk,
  input  logic           rst,
  rle_vli_coder_if.slave bus
`ifdef RLE_VLI_STATS_EN
  ,
  output logic [15:0]    stat_zrl_drop
`endif
);

  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SIZE_W  = $clog2(DATA_WIDTH + 1);
  localparam int IDX_W   = $clog2(BLOCK_LEN);
  localparam int ZRL_MAX = (BLOCK_LEN - 2) / (RUN_MAX + 1);
  localparam int ZRL_W   = (ZRL_MAX > 0) ? $clog2(ZRL_MAX + 1) : 1;

  localparam logic [0:0] ST_ACCEPT = 1'b0;
  localparam logic [0:0] ST_FLUSH  = 1'b1;

  function automatic logic [SIZE_W-1:0] vli_size(input logic signed [DATA_WIDTH:0] v);
    logic [DATA_WIDTH:0] mag;
    logic [SIZE_W-1:0]   s;
    mag = v[DATA_WIDTH] ? (~$unsigned(v) + {{DATA_WIDTH{1'b0}}, 1'b1}) : $unsigned(v);
    s   = '0;
    for (int i = 0; i <= DATA_WIDTH; i++) begin
      if (mag[i]) begin
        s = SIZE_W'(i + 1);
      end else begin
        s = s;
      end
    end
    return s;
  endfunction

  // Negative amplitudes are sent as (v - 1) masked to size bits, i.e. one's complement.
  function automatic logic [DATA_WIDTH-1:0] vli_bits(input logic signed [DATA_WIDTH:0] v,
                                                     input logic [SIZE_W-1:0]         size);
    logic [DATA_WIDTH:0] raw;
    logic [DATA_WIDTH:0] mask;
    raw = v[DATA_WIDTH] ? ($unsigned(v) - {{DATA_WIDTH{1'b0}}, 1'b1}) : $unsigned(v);
    for (int i = 0; i <= DATA_WIDTH; i++) begin
      mask[i] = (SIZE_W'(i) < size);
    end
    return DATA_WIDTH'(raw & mask);
  endfunction

  logic [0:0]            state_r;
  logic [IDX_W-1:0]      idx_r;
  logic [3:0]            run_r;
  logic [ZRL_W-1:0]      zrl_r;
  logic [CH_W-1:0]       ch_r;
  logic [DATA_WIDTH-1:0] pred_r [NUM_CH];

  logic                  out_valid_r;
  logic [3:0]            out_run_r;
  logic [SIZE_W-1:0]     out_size_r;
  logic [DATA_WIDTH-1:0] out_vli_r;
  logic                  out_isdc_r;
  logic                  out_eob_r;
  logic                  out_last_r;
  logic [CH_W-1:0]       out_ch_r;

  logic [3:0]            hold_run_r;
  logic [SIZE_W-1:0]     hold_size_r;
  logic [DATA_WIDTH-1:0] hold_vli_r;
  logic                  hold_last_r;

  logic                         accept_s;
  logic                         fire_s;
  logic                         drain_s;
  logic                         is_dc_s;
  logic                         is_last_s;
  logic                         is_zero_s;
  logic [DATA_WIDTH-1:0]        pred_sel_s;
  logic signed [DATA_WIDTH:0]   coef_ext_s;
  logic signed [DATA_WIDTH:0]   pred_ext_s;
  logic signed [DATA_WIDTH:0]   dc_diff_s;
  logic signed [DATA_WIDTH:0]   sym_val_s;
  logic [SIZE_W-1:0]            sym_size_s;
  logic [DATA_WIDTH-1:0]        sym_vli_s;

  logic [0:0]            state_nx_s;
  logic [IDX_W-1:0]      idx_nx_s;
  logic [3:0]            run_nx_s;
  logic [ZRL_W-1:0]      zrl_nx_s;
  logic [CH_W-1:0]       ch_nx_s;
  logic                  load_s;
  logic                  hold_load_s;
  logic [3:0]            ld_run_s;
  logic [SIZE_W-1:0]     ld_size_s;
  logic [DATA_WIDTH-1:0] ld_vli_s;
  logic                  ld_isdc_s;
  logic                  ld_eob_s;
  logic                  ld_last_s;
  logic [CH_W-1:0]       ld_ch_s;

  assign accept_s  = (state_r == ST_ACCEPT) && (!out_valid_r || bus.out_ready);
  assign fire_s    = bus.in_valid && accept_s;
  assign drain_s   = out_valid_r && bus.out_ready;
  assign is_dc_s   = (idx_r == '0);
  assign is_last_s = (idx_r == IDX_W'(BLOCK_LEN - 1));
  assign is_zero_s = (bus.in_data == '0);

  // Predictor of the addressed channel; an out-of-range channel reads as zero.
  always_comb begin
    pred_sel_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.in_ch == CH_W'(c)) begin
        pred_sel_s = pred_r[c];
      end else begin
        pred_sel_s = pred_sel_s;
      end
    end
  end

  assign coef_ext_s = {bus.in_data[DATA_WIDTH-1], bus.in_data};
  assign pred_ext_s = {pred_sel_s[DATA_WIDTH-1], pred_sel_s};
  assign dc_diff_s  = coef_ext_s - (bus.in_restart ? '0 : pred_ext_s);
  assign sym_val_s  = is_dc_s ? dc_diff_s : coef_ext_s;
  assign sym_size_s = vli_size(sym_val_s);
  assign sym_vli_s  = vli_bits(sym_val_s, sym_size_s);

  // Next-state and output-load decode for both accepted beats and flush handshakes.
  always_comb begin
    state_nx_s  = state_r;
    idx_nx_s    = idx_r;
    run_nx_s    = run_r;
    zrl_nx_s    = zrl_r;
    ch_nx_s     = ch_r;
    load_s      = 1'b0;
    hold_load_s = 1'b0;
    ld_run_s    = 4'd0;
    ld_size_s   = '0;
    ld_vli_s    = '0;
    ld_isdc_s   = 1'b0;
    ld_eob_s    = 1'b0;
    ld_last_s   = 1'b0;
    ld_ch_s     = ch_r;
    if (fire_s) begin
      idx_nx_s = is_last_s ? '0 : idx_r + IDX_W'(1);
      if (is_dc_s) begin
        ch_nx_s   = bus.in_ch;
        ld_ch_s   = bus.in_ch;
        run_nx_s  = 4'd0;
        zrl_nx_s  = '0;
        load_s    = 1'b1;
        ld_size_s = sym_size_s;
        ld_vli_s  = sym_vli_s;
        ld_isdc_s = 1'b1;
      end else if (is_zero_s) begin
        if (is_last_s) begin
          run_nx_s  = 4'd0;
          zrl_nx_s  = '0;
          load_s    = 1'b1;
          ld_eob_s  = 1'b1;
          ld_last_s = 1'b1;
        end else if (run_r == 4'(RUN_MAX)) begin
          run_nx_s = 4'd0;
          zrl_nx_s = zrl_r + ZRL_W'(1);
        end else begin
          run_nx_s = run_r + 4'd1;
        end
      end else if (zrl_r != '0) begin
        state_nx_s  = ST_FLUSH;
        hold_load_s = 1'b1;
        run_nx_s    = 4'd0;
        load_s      = 1'b1;
        ld_run_s    = 4'(RUN_MAX);
      end else begin
        run_nx_s  = 4'd0;
        load_s    = 1'b1;
        ld_run_s  = run_r;
        ld_size_s = sym_size_s;
        ld_vli_s  = sym_vli_s;
        ld_last_s = is_last_s;
      end
    end else if ((state_r == ST_FLUSH) && drain_s) begin
      zrl_nx_s = zrl_r - ZRL_W'(1);
      load_s   = 1'b1;
      if (zrl_r == ZRL_W'(1)) begin
        state_nx_s = ST_ACCEPT;
        ld_run_s   = hold_run_r;
        ld_size_s  = hold_size_r;
        ld_vli_s   = hold_vli_r;
        ld_last_s  = hold_last_r;
      end else begin
        ld_run_s = 4'(RUN_MAX);
      end
    end else begin
      state_nx_s = state_r;
    end
  end

  // Block position, run tracking and flush control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_ACCEPT;
      idx_r   <= '0;
      run_r   <= 4'd0;
      zrl_r   <= '0;
      ch_r    <= '0;
    end else begin
      state_r <= state_nx_s;
      idx_r   <= idx_nx_s;
      run_r   <= run_nx_s;
      zrl_r   <= zrl_nx_s;
      ch_r    <= ch_nx_s;
    end
  end

  // DC predictors: restart clears every channel, then the addressed one takes the new DC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        pred_r[c] <= '0;
      end
    end else if (fire_s && is_dc_s) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.in_ch == CH_W'(c)) begin
          pred_r[c] <= bus.in_data;
        end else if (bus.in_restart) begin
          pred_r[c] <= '0;
        end else begin
          pred_r[c] <= pred_r[c];
        end
      end
    end
  end

  // Symbol parked while its preceding ZRLs drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_run_r  <= 4'd0;
      hold_size_r <= '0;
      hold_vli_r  <= '0;
      hold_last_r <= 1'b0;
    end else if (hold_load_s) begin
      hold_run_r  <= run_r;
      hold_size_r <= sym_size_s;
      hold_vli_r  <= sym_vli_s;
      hold_last_r <= is_last_s;
    end
  end

  // Single output register; fields only change on a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_run_r   <= 4'd0;
      out_size_r  <= '0;
      out_vli_r   <= '0;
      out_isdc_r  <= 1'b0;
      out_eob_r   <= 1'b0;
      out_last_r  <= 1'b0;
      out_ch_r    <= '0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_run_r   <= ld_run_s;
      out_size_r  <= ld_size_s;
      out_vli_r   <= ld_vli_s;
      out_isdc_r  <= ld_isdc_s;
      out_eob_r   <= ld_eob_s;
      out_last_r  <= ld_last_s;
      out_ch_r    <= ld_ch_s;
    end else if (drain_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready  = accept_s && !rst;
  assign bus.out_valid = out_valid_r;
  assign bus.out_run   = out_run_r;
  assign bus.out_size  = out_size_r;
  assign bus.out_vli   = out_vli_r;
  assign bus.out_isdc  = out_isdc_r;
  assign bus.out_eob   = out_eob_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_ch    = out_ch_r;

`ifdef RLE_VLI_STATS_EN
  logic [15:0] stat_r;
  logic [16:0] stat_sum_s;

  assign stat_sum_s = {1'b0, stat_r} + 17'(zrl_r);

  // Saturating tally of pending ZRLs thrown away when a block closes with EOB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_r <= 16'd0;
    end else if (fire_s && !is_dc_s && is_zero_s && is_last_s) begin
      stat_r <= stat_sum_s[16] ? 16'hFFFF : stat_sum_s[15:0];
    end
  end

  assign stat_zrl_drop = stat_r;
`endif

endmodule

// File: tb/tb_rle_vli_coder.sv
// Directed self-checking bench for rle_vli_coder (default parameters).
module tb_rle_vli_coder;

  typedef struct packed {
    logic [3:0]  run;
    logic [3:0]  size;
    logic [10:0] vli;
    logic        isdc;
    logic        eob;
    logic        last;
    logic [1:0]  ch;
  } sym_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   rand_ready = 1'b0;
  sym_t q[$];

  rle_vli_coder_if #(.DATA_WIDTH(11), .NUM_CH(3)) bus ();

`ifdef RLE_VLI_STATS_EN
  logic [15:0] stat_zrl_drop;
`endif

  rle_vli_coder #(
    .DATA_WIDTH(11), .NUM_CH(3), .BLOCK_LEN(64), .RUN_MAX(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef RLE_VLI_STATS_EN
    ,
    .stat_zrl_drop(stat_zrl_drop)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic sym_t cur_sym();
    return {bus.out_run, bus.out_size, bus.out_vli, bus.out_isdc,
            bus.out_eob, bus.out_last, bus.out_ch};
  endfunction

  function automatic sym_t mk(int run, int size, int vli, bit isdc, bit eob, bit last, int ch);
    sym_t s;
    s.run  = 4'(run);
    s.size = 4'(size);
    s.vli  = 11'(vli);
    s.isdc = isdc;
    s.eob  = eob;
    s.last = last;
    s.ch   = 2'(ch);
    return s;
  endfunction

  task automatic chk_sym(input int i, input sym_t e);
    if (i < q.size()) check($sformatf("sym%0d", i), 32'(q[i]), 32'(e));
    else check($sformatf("sym%0d_missing", i), 32'(q.size()), 32'(i + 1));
  endtask

  task automatic send(input int d, input int ch, input bit rs, output int waited);
    waited = 0;
    bus.in_valid   = 1'b1;
    bus.in_data    = 11'(d);
    bus.in_ch      = 2'(ch);
    bus.in_restart = rs;
    @(negedge clk);
    while (!bus.in_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 500) check("in_ready_timeout", 32'(waited), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.in_restart = 1'b0;
  endtask

  task automatic zeros(input int n, input int ch);
    int w;
    for (int i = 0; i < n; i++) send(0, ch, 1'b0, w);
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while (bus.out_valid && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // out_ready: held high, or 30% ready when rand_ready is set
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // Records every output handshake and checks fields hold across stalls
  initial begin
    sym_t prev;
    bit   stalled;
    stalled = 1'b0;
    prev    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) check("stall_stable", 32'({bus.out_valid, cur_sym()}), 32'({1'b1, prev}));
        if (bus.out_valid && bus.out_ready) q.push_back(cur_sym());
        stalled = bus.out_valid && !bus.out_ready;
        prev    = cur_sym();
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int t0;
`ifdef RLE_VLI_STATS_EN
    logic [15:0] stat_before;
`endif
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_ch      = '0;
    bus.in_restart = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", 32'({bus.out_valid, cur_sym()}), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Restart DC 100 then all-zero AC
    q.delete();
    t0 = cyc;
    send(100, 0, 1'b1, w);
    check("dc_latency", 32'({bus.out_valid, bus.out_isdc}), 32'd3);
    zeros(63, 0);
    check("throughput", 32'(cyc - t0), 32'd64);
    drain();
    check("blkA_count", 32'(q.size()), 32'd2);
    chk_sym(0, mk(0, 7, 100, 1, 0, 0, 0));
    chk_sym(1, mk(0, 0, 0, 0, 1, 1, 0));

    // DC 90 on ch0 (pred 100), then DC -5 on ch1 (pred 0)
    q.delete();
    send(90, 0, 1'b0, w);
    zeros(63, 0);
    send(-5, 1, 1'b0, w);
    zeros(63, 1);
    drain();
    check("blkBC_count", 32'(q.size()), 32'd4);
    chk_sym(0, mk(0, 4, 5, 1, 0, 0, 0));
    chk_sym(1, mk(0, 0, 0, 0, 1, 1, 0));
    chk_sym(2, mk(0, 3, 2, 1, 0, 0, 1));
    chk_sym(3, mk(0, 0, 0, 0, 1, 1, 1));

    // 35 zeros, 3, 27 zeros: two ZRLs flushed ahead of the 3
    q.delete();
    send(90, 0, 1'b0, w);
    zeros(35, 0);
    send(3, 0, 1'b0, w);
    send(0, 0, 1'b0, w);
    check("flush_stall_cycles", 32'(w), 32'd2);
    zeros(26, 0);
    drain();
    check("blkD_count", 32'(q.size()), 32'd5);
    chk_sym(0, mk(0, 0, 0, 1, 0, 0, 0));
    chk_sym(1, mk(15, 0, 0, 0, 0, 0, 0));
    chk_sym(2, mk(15, 0, 0, 0, 0, 0, 0));
    chk_sym(3, mk(3, 2, 3, 0, 0, 0, 0));
    chk_sym(4, mk(0, 0, 0, 0, 1, 1, 0));

    // 62 zeros then -1 on the last beat: 3 ZRLs, run 14, no EOB
    q.delete();
`ifdef RLE_VLI_STATS_EN
    stat_before = stat_zrl_drop;
`endif
    send(90, 0, 1'b0, w);
    zeros(62, 0);
    send(-1, 0, 1'b0, w);
    drain();
    check("blkE_count", 32'(q.size()), 32'd5);
    chk_sym(0, mk(0, 0, 0, 1, 0, 0, 0));
    chk_sym(1, mk(15, 0, 0, 0, 0, 0, 0));
    chk_sym(2, mk(15, 0, 0, 0, 0, 0, 0));
    chk_sym(3, mk(15, 0, 0, 0, 0, 0, 0));
    chk_sym(4, mk(14, 1, 0, 0, 0, 1, 0));
`ifdef RLE_VLI_STATS_EN
    check("stat_unchanged", 32'(stat_zrl_drop), 32'(stat_before));
`endif

    // Mixed block under random backpressure
    q.delete();
    rand_ready = 1'b1;
    send(50, 0, 1'b0, w);
    send(-3, 0, 1'b0, w);
    zeros(17, 0);
    send(1, 0, 1'b0, w);
    send(-1024, 0, 1'b0, w);
    send(255, 0, 1'b0, w);
    zeros(42, 0);
    drain();
    rand_ready = 1'b0;
    check("blkF_count", 32'(q.size()), 32'd7);
    chk_sym(0, mk(0, 6, 23, 1, 0, 0, 0));
    chk_sym(1, mk(0, 2, 0, 0, 0, 0, 0));
    chk_sym(2, mk(15, 0, 0, 0, 0, 0, 0));
    chk_sym(3, mk(1, 1, 1, 0, 0, 0, 0));
    chk_sym(4, mk(0, 11, 'h3FF, 0, 0, 0, 0));
    chk_sym(5, mk(0, 8, 255, 0, 0, 0, 0));
    chk_sym(6, mk(0, 0, 0, 0, 1, 1, 0));

    // Reset while flushing ZRLs
    q.delete();
    @(posedge clk);
    #1;
    send(20, 0, 1'b0, w);
    zeros(32, 0);
    send(9, 0, 1'b0, w);
    rst = 1'b1;
    #1;
    check("rst_mid_flush_out", 32'({bus.out_valid, cur_sym()}), 32'd0);
    check("rst_mid_flush_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("ready_after_mid_rst", 32'(bus.in_ready), 32'd1);
    check("blkG_count", 32'(q.size()), 32'd1);
    @(posedge clk);
    #1;

    // Ch1 predictor must be 0 again after reset
    q.delete();
    send(7, 1, 1'b0, w);
    zeros(63, 1);
    drain();
    check("blkH_count", 32'(q.size()), 32'd2);
    chk_sym(0, mk(0, 3, 7, 1, 0, 0, 1));
    chk_sym(1, mk(0, 0, 0, 0, 1, 1, 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
